bcd_scan_display: RTL and testbench
===================================

Name: bcd_scan_display

Overview:
- Consumes the two BCD digits produced by the 4-bit binary-to-BCD stage: D0 is the ones digit and D1 is the tens digit.
- Drives a time-multiplexed two-digit seven-segment display.
- Digit updates go through a Load/Ready handshake. A new value is applied only at a scan-frame boundary, so it never changes mid-frame.
- Provides leading-zero blanking and flags any digit outside 0-9.

Parameters:
- SCAN_DIV, 50000: clock cycles each digit stays active. Minimum 2.
- SEG_ACTIVE_LOW, 1: 1 means segments are lit by a 0 (DE-board style). 0 means lit by a 1.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous active-low reset.
- Load  in  1  request to capture D0/D1; accepted only when Ready=1.
- D0  in  4  ones BCD digit.
- D1  in  4  tens BCD digit.
- Blank  in  1  1 enables leading-zero blanking of the tens digit; sampled live, not captured.
- Ready  out  1  1 means no update is pending and Load will be accepted.
- Seg  out  7  segment drive, bit order {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW.
- DigitEn  out  2  one-hot digit select, active-high; bit0 = ones, bit1 = tens.
- Err  out  1  1 means a displayed digit is greater than 9.

Behaviour:
- Clock and reset:
  - One clock domain.
  - Resetn is asynchronous and active-low.
  - Clock and reset are named Clock and Resetn.
- Reset values, all asynchronous:
  - Display registers = 0, pending register = 0.
  - Divider count = 0, state = SCAN0.
  - Ready = 1, Err = 0, DigitEn = 2'b00.
  - Seg = all segments off (7'h7F when SEG_ACTIVE_LOW=1).
- Reset mid-operation discards any pending update.
- Divider:
  - Counts 0..SCAN_DIV-1 and wraps.
  - Terminal count (TC) is count == SCAN_DIV-1.
- State machine:
  - SCAN0 shows the ones digit; SCAN1 shows the tens digit.
  - SCAN0 -> SCAN1 on TC. SCAN1 -> SCAN0 on TC.
  - No other transitions.
- Frame boundary is TC while in SCAN1.
- Handshake:
  - Load=1 and Ready=1 on an edge: D0/D1 go into the pending register and Ready drops to 0 on that edge.
  - Load while Ready=0 is ignored; the pending value is not overwritten.
  - At the next frame boundary, the pending value moves to the display registers and Ready returns to 1 on that same edge.
  - A Load accepted on the frame-boundary cycle itself is not transferred on that edge. It waits for the following frame boundary.
  - Load held high therefore yields at most one accept per frame.
- Outputs are registered and reflect state/count with one cycle of latency:
  - DigitEn = 2'b01 in SCAN0, 2'b10 in SCAN1.
  - The first non-zero DigitEn appears one cycle after reset release.
- Segment decode:
  - Decodes the active display digit.
  - Digit 0-9: standard patterns. Active-low example: 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000.
  - Digit 10-15: shows "E" (active-low 7'b0000110).
  - With SEG_ACTIVE_LOW=0, every pattern is inverted.
- Blanking:
  - Applies in SCAN1 when Blank=1 and the tens display digit is 0.
  - Seg = all off, but DigitEn still = 2'b10.
  - The ones digit is never blanked, so value 0 shows "0".
- Err:
  - Registered.
  - 1 whenever either display register is greater than 9; updates on the transfer edge.
  - Clears only when a valid pair is transferred, or on reset.
  - A pending invalid value does not set Err until it is transferred.

Decomposition:
- Package bcd_pkg holds:
  - Seven-segment constants SEG_0..SEG_9, SEG_E, SEG_OFF (active-low form).
  - State encoding SCAN0 = 1'b0, SCAN1 = 1'b1.
- One sub-module, bcd_to_seg7: combinational 4-bit to 7-bit active-low decoder, including the "E" case.
- The top level handles polarity inversion and blanking.

Test Plan:
All scenarios use SCAN_DIV=4 and SEG_ACTIVE_LOW=1, giving an 8-cycle frame.
1. Reset, then release -> Ready=1, Err=0. DigitEn walks 01,01,01,01,10,10,10,10 from the cycle after release. Seg = 7'b1000000 in both slots with Blank=0.
2. Load=1 for one cycle with D1=1, D0=5, mid-SCAN0 -> Ready=0 the next cycle. The display stays 0,0 until the frame boundary. After it: ones slot Seg=7'b0010010, tens slot Seg=7'b1111001, Ready=1.
3. Blank=1, load D1=0, D0=7 -> tens slot Seg=7'h7F with DigitEn=10; ones slot Seg=7'b1111000. Then Blank=0 -> tens slot shows 7'b1000000.
4. Load D1=0, D0=12 -> after transfer, Err=1 and ones slot Seg=7'b0000110. Then load 0,3 -> Err=0 after the next frame boundary.
5. Load held high for 3 frames with changing data -> exactly one accept per frame. Loads while Ready=0 do not alter the pending value. A Load on the frame-boundary cycle is applied one frame later.
6. Resetn pulsed low mid-frame while an update is pending -> all outputs take their reset values immediately (asynchronously). The pending value is never displayed, and Ready=1 after release.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants for the two-digit BCD scan display: segment patterns and scan states.
package bcd_pkg;

    // Seven-segment patterns, bit order {g,f,e,d,c,b,a}, active-low (0 lights a segment)
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Which digit is being scanned: SCAN0 = ones, SCAN1 = tens
    typedef enum logic {
        SCAN0 = 1'b0,
        SCAN1 = 1'b1
    } scan_state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 show "E".
module bcd_to_seg7
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Pattern lookup for one digit
    always_comb begin
        seg = SEG_E;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Two-digit multiplexed seven-segment driver with frame-synchronous load handshake,
// leading-zero blanking of the tens digit and an out-of-range digit flag.
module bcd_scan_display
    import bcd_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Load,
    input  logic [3:0] D0,
    input  logic [3:0] D1,
    input  logic       Blank,
    output logic       Ready,
    output logic [6:0] Seg,
    output logic [1:0] DigitEn,
    output logic       Err
);

    localparam int         CNT_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [6:0] SEG_RESET = SEG_ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;

    logic [CNT_W-1:0] count;
    scan_state_t      state;
    scan_state_t      next_state;
    logic             tc;
    logic             boundary;
    logic [3:0]       disp_d0;
    logic [3:0]       disp_d1;
    logic [3:0]       pend_d0;
    logic [3:0]       pend_d1;
    logic [3:0]       active_digit;
    logic [6:0]       dec_seg;
    logic [6:0]       seg_low;
    logic             blank_now;

    assign tc       = (count == CNT_W'(SCAN_DIV - 1));
    assign boundary = tc && (state == SCAN1);

    // Per-digit dwell divider, wraps at terminal count
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) count <= '0;
        else         count <= tc ? '0 : count + 1'b1;
    end

    // Scan state register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= SCAN0;
        else         state <= next_state;
    end

    // Scan state transitions: alternate digits on each terminal count
    always_comb begin
        next_state = state;
        case (state)
            SCAN0:   if (tc) next_state = SCAN1;
            SCAN1:   if (tc) next_state = SCAN0;
            default: next_state = SCAN0;
        endcase
    end

    // Load handshake: capture into pending, move to display at the frame boundary.
    // A transfer takes priority; a load arriving while Ready=0 is dropped.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pend_d0 <= '0;
            pend_d1 <= '0;
            disp_d0 <= '0;
            disp_d1 <= '0;
            Ready   <= 1'b1;
            Err     <= 1'b0;
        end else if (boundary && !Ready) begin
            disp_d0 <= pend_d0;
            disp_d1 <= pend_d1;
            Ready   <= 1'b1;
            Err     <= (pend_d0 > 4'd9) || (pend_d1 > 4'd9);
        end else if (Load && Ready) begin
            pend_d0 <= D0;
            pend_d1 <= D1;
            Ready   <= 1'b0;
        end
    end

    assign active_digit = (state == SCAN0) ? disp_d0 : disp_d1;
    assign blank_now    = (state == SCAN1) && Blank && (disp_d1 == 4'd0);

    bcd_to_seg7 u_dec (
        .digit (active_digit),
        .seg   (dec_seg)
    );

    assign seg_low = blank_now ? SEG_OFF : dec_seg;

    // Registered display outputs, one cycle behind state/count
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Seg     <= SEG_RESET;
            DigitEn <= 2'b00;
        end else begin
            Seg     <= SEG_ACTIVE_LOW ? seg_low : ~seg_low;
            DigitEn <= (state == SCAN0) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with SCAN_DIV=4 (8-cycle frame), active-low segments.
module tb_bcd_scan_display;

    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S6   = 7'b0000010;
    localparam logic [6:0] S7   = 7'b1111000;
    localparam logic [6:0] S8   = 7'b0000000;
    localparam logic [6:0] S9   = 7'b0010000;
    localparam logic [6:0] SE   = 7'b0000110;
    localparam logic [6:0] SOFF = 7'h7F;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       Load = 1'b0;
    logic [3:0] D0 = 4'd0;
    logic [3:0] D1 = 4'd0;
    logic       Blank = 1'b0;
    logic       Ready;
    logic [6:0] Seg;
    logic [1:0] DigitEn;
    logic       Err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] d1;
        logic [3:0] d0;
        logic       blank;
        logic [6:0] ones;
        logic [6:0] tens;
        logic       err;
    } vec_t;

    vec_t vecs [8];

    bcd_scan_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Load    (Load),
        .D0      (D0),
        .D1      (D1),
        .Blank   (Blank),
        .Ready   (Ready),
        .Seg     (Seg),
        .DigitEn (DigitEn),
        .Err     (Err)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [6:0] prev_ones;
        logic       prev_ready;
        int         accepts;

        vecs[0] = '{d1: 4'd1,  d0: 4'd5,  blank: 1'b0, ones: S5, tens: S1,   err: 1'b0};
        vecs[1] = '{d1: 4'd0,  d0: 4'd7,  blank: 1'b1, ones: S7, tens: SOFF, err: 1'b0};
        vecs[2] = '{d1: 4'd0,  d0: 4'd7,  blank: 1'b0, ones: S7, tens: S0,   err: 1'b0};
        vecs[3] = '{d1: 4'd0,  d0: 4'd12, blank: 1'b0, ones: SE, tens: S0,   err: 1'b1};
        vecs[4] = '{d1: 4'd0,  d0: 4'd3,  blank: 1'b1, ones: S3, tens: SOFF, err: 1'b0};
        vecs[5] = '{d1: 4'd9,  d0: 4'd8,  blank: 1'b1, ones: S8, tens: S9,   err: 1'b0};
        vecs[6] = '{d1: 4'd2,  d0: 4'd4,  blank: 1'b0, ones: S4, tens: S2,   err: 1'b0};
        vecs[7] = '{d1: 4'd14, d0: 4'd0,  blank: 1'b1, ones: S0, tens: SE,   err: 1'b1};

        // Reset state
        #12;
        chk("reset_ready", Ready, 1'b1);
        chk("reset_err", Err, 1'b0);
        chk("reset_digiten", DigitEn, 2'b00);
        chk("reset_seg", Seg, SOFF);
        @(negedge Clock);
        Resetn = 1'b1;

        // First frame after release: digit walk, zeros shown
        for (int s = 0; s < 8; s++) begin
            tick();
            chk("walk_digiten", DigitEn, (s < 4) ? 2'b01 : 2'b10);
            chk("walk_seg", Seg, S0);
            chk("walk_ready", Ready, 1'b1);
        end

        // Table: load mid-SCAN0, transfer at boundary, verify following frame
        prev_ones = S0;
        for (int i = 0; i < 8; i++) begin
            Blank = vecs[i].blank;
            tick();
            tick();
            Load = 1'b1;
            D1   = vecs[i].d1;
            D0   = vecs[i].d0;
            tick();
            Load = 1'b0;
            D1   = 4'd0;
            D0   = 4'd0;
            chk("vec_ready_low", Ready, 1'b0);
            tick();
            chk("vec_old_ones", Seg, prev_ones);
            for (int k = 0; k < 4; k++) tick();
            chk("vec_ready_back", Ready, 1'b1);
            chk("vec_err", Err, vecs[i].err);
            for (int s = 0; s < 8; s++) begin
                tick();
                chk("vec_digiten", DigitEn, (s < 4) ? 2'b01 : 2'b10);
                chk("vec_seg", Seg, (s < 4) ? vecs[i].ones : vecs[i].tens);
            end
            prev_ones = vecs[i].ones;
        end

        // Asynchronous reset with an update pending
        Blank = 1'b0;
        tick();
        tick();
        Load = 1'b1;
        D1   = 4'd4;
        D0   = 4'd4;
        tick();
        Load = 1'b0;
        chk("rst_pending", Ready, 1'b0);
        chk("rst_err_before", Err, 1'b1);
        #2 Resetn = 1'b0;
        #1;
        chk("async_ready", Ready, 1'b1);
        chk("async_err", Err, 1'b0);
        chk("async_digiten", DigitEn, 2'b00);
        chk("async_seg", Seg, SOFF);
        @(negedge Clock);
        chk("held_rst_seg", Seg, SOFF);
        Resetn = 1'b1;
        for (int s = 0; s < 16; s++) begin
            tick();
            chk("post_rst_seg", Seg, S0);
            chk("post_rst_ready", Ready, 1'b1);
            chk("post_rst_digiten", DigitEn, ((s % 8) < 4) ? 2'b01 : 2'b10);
        end
        chk("post_rst_err", Err, 1'b0);

        // Load held high for three frames with data changing every cycle
        accepts    = 0;
        prev_ready = Ready;
        Load       = 1'b1;
        for (int k = 0; k < 24; k++) begin
            D0 = 4'(k % 10);
            D1 = 4'((k / 3) % 10);
            tick();
            if (prev_ready && !Ready) accepts++;
            prev_ready = Ready;
            if (k == 16) chk("held_mid_ones", Seg, S8);
            if (k == 20) chk("held_mid_tens", Seg, S2);
        end
        Load = 1'b0;
        chk("held_accepts", accepts, 3);
        for (int s = 0; s < 8; s++) begin
            tick();
            if (s == 0) chk("held_final_ones", Seg, S6);
            if (s == 4) chk("held_final_tens", Seg, S5);
        end

        // Load on the frame-boundary cycle waits a full frame
        for (int k = 0; k < 7; k++) tick();
        Load = 1'b1;
        D1   = 4'd7;
        D0   = 4'd1;
        tick();
        Load = 1'b0;
        chk("bnd_accepted", Ready, 1'b0);
        tick();
        chk("bnd_not_shown", Seg, S6);
        for (int k = 0; k < 6; k++) tick();
        chk("bnd_still_pending", Ready, 1'b0);
        tick();
        chk("bnd_ready_back", Ready, 1'b1);
        tick();
        chk("bnd_ones", Seg, S1);
        for (int k = 0; k < 4; k++) tick();
        chk("bnd_tens", Seg, S7);
        chk("bnd_tens_digiten", DigitEn, 2'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
